camera_pixel_capture: RTL and testbench
=======================================

# camera_pixel_capture

Upstream stage of the Sobel path. Samples the OV7670 parallel bus (vsync, href, 8-bit data, all synchronous to the camera pixel clock), pairs bytes into RGB565 pixels, and writes them into the camera FIFO that the Sobel convolution stage drains. It frames capture on vsync, discards settling frames after enable, validates line and frame geometry, and drops the rest of a frame on FIFO overflow so the downstream 3-line counter never sees a torn frame.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line (two bytes each)
- V_ACTIVE, 480, lines per frame
- SKIP_FRAMES, 2, complete frames discarded after capture_en rises (0 allowed)

Ports:
- clk  in  1  camera pixel clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- capture_en  in  1  level; start/stop capture, honoured only at frame boundaries
- cam_vsync  in  1  high during vertical blanking
- cam_href  in  1  high while line bytes are valid
- cam_data  in  8  byte bus; high byte of each pixel first
- fifo_full  in  1  camera FIFO full flag
- fifo_wr  out  1  one-cycle write strobe per pixel
- fifo_din  out  16  RGB565 pixel, valid when fifo_wr=1
- frame_done  out  1  one-cycle pulse: clean frame fully written
- frame_err  out  1  one-cycle pulse: frame ended with geometry error
- overflow  out  1  sticky; set on any dropped pixel, cleared when capture_en=0 or reset
- busy  out  1  high in SKIP, CAPTURE, DROP

## Operation
- Inputs registered once (vs_r, hr_r, d_r); edges detected from vs_r/hr_r versus their previous value.
- States: IDLE, WAIT_VS, SKIP, CAPTURE, DROP.
- IDLE: capture_en=1 -> WAIT_VS; skip counter loaded with SKIP_FRAMES.
- WAIT_VS: on vs_r falling edge: skip counter nonzero -> SKIP, else -> CAPTURE; capture_en=0 -> IDLE.
- SKIP: on vs_r rising edge decrement counter; reaching 0 -> WAIT_VS.
- CAPTURE: while hr_r=1, byte phase toggles; phase 0 stores d_r as high byte, phase 1 forms {high, d_r}, increments x_cnt, requests write. On hr_r falling: phase 1 pending (odd byte count) or x_cnt != H_ACTIVE sets err flag; x_cnt and phase cleared; y_cnt increments. On vs_r rising: y_cnt==V_ACTIVE and err=0 -> frame_done, else frame_err; counters/err cleared; capture_en=1 -> WAIT_VS (skip counter 0), else -> IDLE.
- Pixels beyond H_ACTIVE in a line, or on lines beyond V_ACTIVE, are not written (err set).
- Overflow: write request while fifo_full=1 -> pixel dropped, overflow set, -> DROP. DROP ignores data; on vs_r rising pulses frame_err, then same exit as CAPTURE.
- capture_en=0 mid-frame: frame completes normally, then IDLE.
- Reset mid-frame: all state cleared; next capture restarts from WAIT_VS (partial frame never resumed).

## Timing
- Reset values: fifo_wr=0, fifo_din=0, frame_done=0, frame_err=0, overflow=0, busy=0, state IDLE.
- Latency: second byte on cam_data at edge N -> fifo_wr=1 with fifo_din valid at edge N+2 (input reg + output reg).
- fifo_full sampled in the same cycle the write request is formed (edge N+1).
- fifo_din holds last written value when fifo_wr=0.
- frame_done/frame_err assert 2 cycles after the vsync rising edge on pins; exactly one of them per captured frame; never both.
- Max throughput: one write every 2 cycles.

## Configuration
- CAM_TEST_PATTERN_EN defined: cam_data ignored in CAPTURE; each pixel replaced by 16'hFFFF when x_cnt[5]=1 else 16'h0000 (32-pixel vertical bars, sharp edges for Sobel checks); timing, counters, and error logic still driven by real vsync/href.
- Undefined: camera bytes passed through unmodified.

## Structure
- Package cam_pkg: state enum, default H_ACTIVE/V_ACTIVE constants, test-pattern function.
- One sub-module cam_sync_edge: input registers plus rise/fall detection for vsync and href.

## Test plan
- SKIP_FRAMES=0, 4x2 frame (H_ACTIVE=4, V_ACTIVE=2), bytes 0x12,0x34,... -> 8 writes, first fifo_din=16'h1234, frame_done pulse once, overflow=0.
- SKIP_FRAMES=2, three frames -> no writes for first two, third frame written, busy high from first vsync fall.
- Line of 3 pixels with H_ACTIVE=4 -> frame_err pulse, no frame_done.
- fifo_full=1 at 3rd pixel -> exactly 2 writes, overflow=1, frame_err at vsync rise, next frame captured normally with overflow still 1 until capture_en=0.
- capture_en dropped mid-frame -> frame finishes with frame_done, state IDLE, busy=0, no further writes.
- CAM_TEST_PATTERN_EN, H_ACTIVE=64 -> pixels 0-31 = 16'h0000, 32-63 = 16'hFFFF.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 capture path.
// CAM_TEST_PATTERN_EN (see camera_pixel_capture) selects test_pattern_pixel().
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_SKIP,
        ST_CAPTURE,
        ST_DROP
    } cam_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    // Width of the pixel/line counters. This is wide enough for any realistic sensor geometry.
    localparam int CNT_W  = 16;
    localparam int SKIP_W = 8;

    // Produces 32-pixel-wide black/white vertical bars. Their sharp edges give the Sobel stage a known response.
    function automatic logic [15:0] test_pattern_pixel(input logic [CNT_W-1:0] x);
        return x[5] ? 16'hFFFF : 16'h0000;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers the camera bus once and derives vsync/href edges from the registered copies.
module cam_sync_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] data,
    output logic       hr_r,
    output logic [7:0] d_r,
    output logic       vs_rise,
    output logic       vs_fall,
    output logic       hr_fall
);

    logic vs_r;
    logic vs_prev;
    logic hr_prev;

    // Input register stage followed by a one-cycle history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r    <= 1'b0;
            hr_r    <= 1'b0;
            d_r     <= 8'h00;
            vs_prev <= 1'b0;
            hr_prev <= 1'b0;
        end else begin
            vs_r    <= vsync;
            hr_r    <= href;
            d_r     <= data;
            vs_prev <= vs_r;
            hr_prev <= hr_r;
        end
    end

    assign vs_rise = vs_r & ~vs_prev;
    assign vs_fall = ~vs_r & vs_prev;
    assign hr_fall = ~hr_r & hr_prev;

endmodule

// File: rtl/camera_pixel_capture.sv
// OV7670 parallel-bus capture: pairs bytes into RGB565 pixels and writes them to the camera FIFO.
// Whole frames are framed on vsync, and geometry is validated per line and per frame.
// On overflow, the rest of the frame is dropped.
// Build option: CAM_TEST_PATTERN_EN replaces camera pixels with 32-pixel vertical bars.
//
// FIFO handshake: fifo_wr is a one-cycle valid strobe carrying fifo_din.
// fifo_full is the inverse of ready. It is sampled in the cycle the write request is formed.
// A request that meets fifo_full=1 is never retried. Instead, the pixel is dropped and the frame is abandoned.
module camera_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [15:0] fifo_din,
    output logic        frame_done,
    output logic        frame_err,
    output logic        overflow,
    output logic        busy
);

    localparam logic [CNT_W-1:0]  H_LIM    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_LIM    = CNT_W'(V_ACTIVE);
    localparam logic [SKIP_W-1:0] SKIP_INI = SKIP_W'(SKIP_FRAMES);

    logic       hr_r;
    logic [7:0] d_r;
    logic       vs_rise;
    logic       vs_fall;
    logic       hr_fall;

    cam_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .vsync   (cam_vsync),
        .href    (cam_href),
        .data    (cam_data),
        .hr_r    (hr_r),
        .d_r     (d_r),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hr_fall (hr_fall)
    );

    cam_state_t        state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [CNT_W-1:0]  x_cnt;
    logic [CNT_W-1:0]  y_cnt;
    logic              phase;
    logic              err;
    logic [7:0]        hi_byte;
    logic              wr_req;
    logic [15:0]       pix_q;
    logic              done_req;
    logic              err_req;

    // Capture FSM plus a one-stage output pipeline.
    // Requests and frame results are registered once more before reaching the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            skip_cnt   <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            phase      <= 1'b0;
            err        <= 1'b0;
            hi_byte    <= 8'h00;
            wr_req     <= 1'b0;
            pix_q      <= 16'h0000;
            done_req   <= 1'b0;
            err_req    <= 1'b0;
            fifo_wr    <= 1'b0;
            fifo_din   <= 16'h0000;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_req     <= 1'b0;
            done_req   <= 1'b0;
            err_req    <= 1'b0;
            fifo_wr    <= wr_req;
            frame_done <= done_req;
            frame_err  <= err_req;
            if (wr_req) begin
                fifo_din <= pix_q;
            end
            if (!capture_en) begin
                overflow <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (capture_en) begin
                        state    <= ST_WAIT_VS;
                        skip_cnt <= SKIP_INI;
                    end
                end

                ST_WAIT_VS: begin
                    if (!capture_en) begin
                        state <= ST_IDLE;
                    end else if (vs_fall) begin
                        state <= (skip_cnt != '0) ? ST_SKIP : ST_CAPTURE;
                        busy  <= 1'b1;
                    end
                end

                ST_SKIP: begin
                    if (vs_rise) begin
                        skip_cnt <= skip_cnt - 1'b1;
                        if (!capture_en) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (skip_cnt == SKIP_W'(1)) begin
                            state <= ST_WAIT_VS;
                            busy  <= 1'b0;
                        end
                    end
                end

                ST_CAPTURE, ST_DROP: begin
                    if (vs_rise) begin
                        // End of frame: report exactly one result and return to frame-boundary waiting.
                        if (state == ST_CAPTURE && y_cnt == V_LIM && !err) begin
                            done_req <= 1'b1;
                        end else begin
                            err_req <= 1'b1;
                        end
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        phase    <= 1'b0;
                        err      <= 1'b0;
                        skip_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= capture_en ? ST_WAIT_VS : ST_IDLE;
                    end else if (state == ST_CAPTURE) begin
                        if (hr_r) begin
                            phase <= ~phase;
                            if (!phase) begin
                                hi_byte <= d_r;
                            end else if (x_cnt >= H_LIM || y_cnt >= V_LIM) begin
                                err <= 1'b1;
                            end else begin
                                x_cnt <= x_cnt + 1'b1;
                                if (fifo_full) begin
                                    overflow <= 1'b1;
                                    state    <= ST_DROP;
                                end else begin
                                    wr_req <= 1'b1;
`ifdef CAM_TEST_PATTERN_EN
                                    pix_q  <= test_pattern_pixel(x_cnt);
`else
                                    pix_q  <= {hi_byte, d_r};
`endif
                                end
                            end
                        end else if (hr_fall) begin
                            if (phase || x_cnt != H_LIM) begin
                                err <= 1'b1;
                            end
                            x_cnt <= '0;
                            phase <= 1'b0;
                            if (y_cnt <= V_LIM) begin
                                y_cnt <= y_cnt + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Self-checking bench for camera_pixel_capture: scoreboarded pixel stream, frame results, flags.
module tb_camera_pixel_capture;

`ifdef CAM_TEST_PATTERN_EN
    localparam int H = 64;
`else
    localparam int H = 4;
`endif
    localparam int V    = 2;
    localparam int SKIP = 2;

    logic        clk;
    logic        rst_n;
    logic        capture_en;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        fifo_full;
    logic        fifo_wr;
    logic [15:0] fifo_din;
    logic        frame_done;
    logic        frame_err;
    logic        overflow;
    logic        busy;

    camera_pixel_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SKIP_FRAMES (SKIP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_en (capture_en),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_din   (fifo_din),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [15:0] exp_q[$];
    int checks = 0;
    int fails = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int first_wr_cyc = -1;
    int pulse_cyc = -1;
    int pix0_cyc = 0;
    int vs_rise_cyc = 0;
    int cfg_full_pix = -1;
    bit cfg_drop_en = 1'b0;
    bit busy_seen = 1'b0;
    logic [7:0] byte_val = 8'h12;

    function automatic logic [15:0] model_pixel(input int x, input logic [7:0] hi, input logic [7:0] lo);
`ifdef CAM_TEST_PATTERN_EN
        return (((x / 32) % 2) == 1) ? 16'hFFFF : 16'h0000;
`else
        return {hi, lo};
`endif
    endfunction

    // Output monitor: pops the expected queue on every write and tallies frame results.
    always @(negedge clk) begin
        logic [15:0] exp;
        if (rst_n) begin
            if (fifo_wr) begin
                wr_cnt++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: fifo_din=%h, expected no write", fifo_din);
                end else begin
                    exp = exp_q.pop_front();
                    if (fifo_din !== exp) begin
                        fails++;
                        $display("FAIL pixel_data: got %h, expected %h", fifo_din, exp);
                    end
                end
            end
            if (frame_done) begin
                done_cnt++;
                pulse_cyc = cyc;
            end
            if (frame_err) begin
                err_cnt++;
                pulse_cyc = cyc;
            end
            if (frame_done || frame_err) begin
                checks++;
                if (frame_done && frame_err) begin
                    fails++;
                    $display("FAIL done_and_err: both pulses high at cycle %0d", cyc);
                end
            end
        end
    end

    // Driver: one frame of V lines.
    // The first line carries n_pix0 pixels, and the remaining lines carry n_pix pixels.
    task automatic send_frame(input int n_pix0, input int n_pix, input bit expect_wr);
        int pix_idx;
        logic [7:0] hi;
        first_wr_cyc = -1;
        pix_idx = 0;
        repeat (3) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (3) @(negedge clk);
        busy_seen = busy;
        for (int ln = 0; ln < V; ln++) begin
            int np;
            np = (ln == 0) ? n_pix0 : n_pix;
            if (cfg_drop_en && ln == 1) capture_en = 1'b0;
            for (int p = 0; p < np; p++) begin
                @(negedge clk);
                cam_href = 1'b1;
                cam_data = byte_val;
                hi = byte_val;
                byte_val = byte_val + 8'h22;
                @(negedge clk);
                cam_data = byte_val;
                if (pix_idx == cfg_full_pix) fifo_full = 1'b1;
                if (pix_idx == 0) pix0_cyc = cyc;
                if (expect_wr && (cfg_full_pix < 0 || pix_idx < cfg_full_pix))
                    exp_q.push_back(model_pixel(p, hi, byte_val));
                byte_val = byte_val + 8'h22;
                pix_idx++;
            end
            @(negedge clk);
            cam_href = 1'b0;
            repeat (3) @(negedge clk);
        end
        cam_vsync = 1'b1;
        vs_rise_cyc = cyc;
        repeat (6) @(negedge clk);
        fifo_full = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        capture_en = 1'b0;
        cam_vsync = 1'b1;
        cam_href = 1'b0;
        cam_data = 8'h00;
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (fifo_wr !== 1'b0)     begin fails++; $display("FAIL reset_fifo_wr: got %b, expected 0", fifo_wr); end
        if (fifo_din !== 16'h0)   begin fails++; $display("FAIL reset_fifo_din: got %h, expected 0000", fifo_din); end
        if (frame_done !== 1'b0)  begin fails++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
        if (frame_err !== 1'b0)   begin fails++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        if (overflow !== 1'b0)    begin fails++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_skip;
        capture_en = 1'b1;
        send_frame(H, H, 1'b0);
        checks++;
        if (busy_seen !== 1'b1) begin fails++; $display("FAIL skip_busy: got %b, expected 1 after first vsync fall", busy_seen); end
        send_frame(H, H, 1'b0);
        checks++;
        if (wr_cnt != 0 || done_cnt != 0 || err_cnt != 0) begin
            fails++;
            $display("FAIL skip_quiet: writes=%0d done=%0d err=%0d, expected 0/0/0", wr_cnt, done_cnt, err_cnt);
        end
        byte_val = 8'h12;
        send_frame(H, H, 1'b1);
        checks += 3;
        if (wr_cnt != H * V) begin fails++; $display("FAIL skip_writes: got %0d, expected %0d", wr_cnt, H * V); end
        if (done_cnt != 1 || err_cnt != 0) begin fails++; $display("FAIL skip_done: done=%0d err=%0d, expected 1/0", done_cnt, err_cnt); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL skip_overflow: got %b, expected 0", overflow); end
    endtask

    task automatic test_back_to_back;
        send_frame(H, H, 1'b1);
        checks += 4;
        if (first_wr_cyc - pix0_cyc != 3) begin fails++; $display("FAIL write_latency: got %0d, expected 3", first_wr_cyc - pix0_cyc); end
        if (pulse_cyc - vs_rise_cyc != 3) begin fails++; $display("FAIL done_latency: got %0d, expected 3", pulse_cyc - vs_rise_cyc); end
        if (done_cnt != 2) begin fails++; $display("FAIL b2b_done: got %0d, expected 2", done_cnt); end
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy: got %b, expected 0 between frames", busy); end
        send_frame(H, H, 1'b1);
        checks += 2;
        if (done_cnt != 3) begin fails++; $display("FAIL b2b_done2: got %0d, expected 3", done_cnt); end
        if (wr_cnt != 3 * H * V) begin fails++; $display("FAIL b2b_writes: got %0d, expected %0d", wr_cnt, 3 * H * V); end
    endtask

    task automatic test_short_line;
        send_frame(H - 1, H, 1'b1);
        checks += 2;
        if (err_cnt != 1) begin fails++; $display("FAIL short_err: got %0d, expected 1", err_cnt); end
        if (done_cnt != 3) begin fails++; $display("FAIL short_done: got %0d, expected 3", done_cnt); end
    endtask

    task automatic test_overflow;
        int w0;
        w0 = wr_cnt;
        cfg_full_pix = 2;
        send_frame(H, H, 1'b1);
        cfg_full_pix = -1;
        checks += 3;
        if (wr_cnt - w0 != 2) begin fails++; $display("FAIL ovf_writes: got %0d, expected 2", wr_cnt - w0); end
        if (err_cnt != 2) begin fails++; $display("FAIL ovf_err: got %0d, expected 2", err_cnt); end
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
        send_frame(H, H, 1'b1);
        checks += 2;
        if (done_cnt != 4) begin fails++; $display("FAIL ovf_recover_done: got %0d, expected 4", done_cnt); end
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
    endtask

    task automatic test_capture_off;
        int w0;
        cfg_drop_en = 1'b1;
        send_frame(H, H, 1'b1);
        cfg_drop_en = 1'b0;
        checks += 3;
        if (done_cnt != 5) begin fails++; $display("FAIL off_done: got %0d, expected 5", done_cnt); end
        if (busy !== 1'b0) begin fails++; $display("FAIL off_busy: got %b, expected 0", busy); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL off_overflow: got %b, expected 0", overflow); end
        w0 = wr_cnt;
        send_frame(H, H, 1'b0);
        checks += 2;
        if (wr_cnt != w0) begin fails++; $display("FAIL off_writes: got %0d, expected %0d", wr_cnt, w0); end
        if (done_cnt != 5 || err_cnt != 2) begin fails++; $display("FAIL off_pulses: done=%0d err=%0d, expected 5/2", done_cnt, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_back_to_back();
        test_short_line();
        test_overflow();
        test_capture_off();
        checks++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL queue_drain: %0d pixels never written, expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
